// File: rtl/combine_pipe.sv
// combine_pipe: valid/ready pipeline that registers an operand pair, combines it
// with a per-item bitwise operation (AND/OR/XOR/pass A), then delays the result
// through DEPTH-2 further register stages. Stalls collapse bubbles and a
// synchronous flush empties every stage.
// Optional feature: define COMBINE_PIPE_CNT_EN to add the xfer_cnt output, a
// wrapping count of completed output transfers.
module combine_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef COMBINE_PIPE_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  // Reject parameter values the structure cannot support.
  if (WIDTH < 1 || DEPTH < 2 || CNT_W < 1) begin : g_param_check
    $error("combine_pipe: WIDTH>=1, DEPTH>=2 and CNT_W>=1 are required");
  end

  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  logic [DEPTH:1]   stage_valid;
  logic [DEPTH:1]   stage_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_mode;
  logic [WIDTH-1:0] stage_data [2:DEPTH];
  logic [WIDTH-1:0] combined;

  // A stage may advance when it, or any stage downstream of it, is empty, or
  // when the consumer takes the output. Written as a reduction over the valid
  // bits so the chain is a plain combinational path from out_ready.
  for (genvar k = 1; k <= DEPTH; k++) begin : g_ready
    assign stage_ready[k] = out_ready | ~(&stage_valid[DEPTH:k]);
  end

  assign in_ready  = stage_ready[1] & ~flush;
  assign out_valid = stage_valid[DEPTH];
  assign out_data  = stage_data[DEPTH];

  // Valid bits: each stage takes its upstream valid when it advances; flush
  // empties everything at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
    end else if (flush) begin
      stage_valid <= '0;
    end else begin
      if (stage_ready[1]) begin
        stage_valid[1] <= in_valid;
      end
      for (int k = 2; k <= DEPTH; k++) begin
        if (stage_ready[k]) begin
          stage_valid[k] <= stage_valid[k-1];
        end
      end
    end
  end

  // Stage 1 captures both operands and the operation together, so later
  // changes on in_mode never affect an item already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_mode <= MODE_AND;
    end else if (stage_ready[1]) begin
      op_a    <= in_a;
      op_b    <= in_b;
      op_mode <= in_mode;
    end
  end

  // Bitwise combine of the captured pair; no carries, result stays WIDTH bits.
  always_comb begin
    combined = op_a & op_b;
    case (op_mode)
      MODE_AND:  combined = op_a & op_b;
      MODE_OR:   combined = op_a | op_b;
      MODE_XOR:  combined = op_a ^ op_b;
      MODE_PASS: combined = op_a;
      default:   combined = op_a & op_b;
    endcase
  end

  // Result register (stage 2) followed by the delay stages; a stalled stage
  // keeps its data so out_data holds while the consumer is not ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 2; k <= DEPTH; k++) begin
        stage_data[k] <= '0;
      end
    end else begin
      if (stage_ready[2]) begin
        stage_data[2] <= combined;
      end
      for (int k = 3; k <= DEPTH; k++) begin
        if (stage_ready[k]) begin
          stage_data[k] <= stage_data[k-1];
        end
      end
    end
  end

`ifdef COMBINE_PIPE_CNT_EN
  // Count completed output transfers; only reset clears it, flush does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_combine_pipe.sv
// tb_combine_pipe: directed vectors with hand-computed results for combine_pipe
// (WIDTH=8, DEPTH=3, CNT_W=8). Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
module tb_combine_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef COMBINE_PIPE_CNT_EN
  logic [CNT_W-1:0] xfer_cnt;
`endif

  int n_vectors     = 0;
  int n_miscompares = 0;

  // streaming vectors: XOR, OR, pass A, AND
  logic [7:0] st_a   [4] = '{8'hAA, 8'h0F, 8'h77, 8'hFF};
  logic [7:0] st_b   [4] = '{8'h55, 8'h10, 8'h00, 8'h81};
  logic [1:0] st_m   [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
  logic [7:0] st_exp [4] = '{8'hFF, 8'h1F, 8'h77, 8'h81};

  // backpressure items (pass A), expected per-cycle output table
  logic [7:0] bp_items [5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic       bp_vld   [12] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [7:0] bp_dat   [12] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h11, 8'h11,
                                8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00};

  always #5 clk = ~clk;

  combine_pipe #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef COMBINE_PIPE_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one input beat.
  task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] mode);
    in_valid = valid;
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    logic exp_rdy;

    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00);

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'h00);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    next_cycle();

    // Single AND: F0 & 3C = 30, visible in cycle 3 only
    applyStimulus(1'b1, 8'hF0, 8'h3C, 2'b00);
    @(negedge clk);
    checkOutput("single_in_ready", 32'(in_ready), 32'd1);
    next_cycle();
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkOutput("single_valid", 32'(out_valid), (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) checkOutput("single_data", 32'(out_data), 32'h30);
      next_cycle();
    end

    // Back-to-back stream, results on cycles 3..6
    for (int c = 0; c < 8; c++) begin
      if (c < 4) applyStimulus(1'b1, st_a[c], st_b[c], st_m[c]);
      else       applyStimulus(1'b0, 8'h00, 8'h00, 2'b00);
      @(negedge clk);
      if (c < 4) checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
      if (c >= 3 && c <= 6) begin
        checkOutput("stream_valid", 32'(out_valid), 32'd1);
        checkOutput("stream_data", 32'(out_data), 32'(st_exp[c-3]));
      end else begin
        checkOutput("stream_idle", 32'(out_valid), 32'd0);
      end
      next_cycle();
    end

    // Backpressure: out_ready low for cycles 0..5, input held valid until cycle 7
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      out_ready = (c >= 6);
      if (c <= 7) applyStimulus(1'b1, bp_items[idx], 8'h5A, 2'b11);
      else        applyStimulus(1'b0, 8'h00, 8'h00, 2'b00);
      exp_rdy = (c < 3) || (c >= 6);
      @(negedge clk);
      if (c <= 7) checkOutput("bp_in_ready", 32'(in_ready), 32'(exp_rdy));
      checkOutput("bp_valid", 32'(out_valid), 32'(bp_vld[c]));
      if (bp_vld[c]) checkOutput("bp_data", 32'(out_data), 32'(bp_dat[c]));
      if (c <= 7 && exp_rdy) idx++;
      next_cycle();
    end
    checkOutput("bp_accepted", 32'(idx), 32'd5);

    // Flush with three items in flight and a simultaneous in_valid
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'hC3, 8'h0F, 2'b00);
    next_cycle();
    applyStimulus(1'b1, 8'h12, 8'h21, 2'b10);
    next_cycle();
    applyStimulus(1'b1, 8'h40, 8'h04, 2'b01);
    next_cycle();
    applyStimulus(1'b1, 8'hEE, 8'h00, 2'b11);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    checkOutput("flush_last_valid", 32'(out_valid), 32'd1);
    checkOutput("flush_last_data", 32'(out_data), 32'h03);
    next_cycle();
    flush = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00);
    @(negedge clk);
    checkOutput("flush_cleared", 32'(out_valid), 32'd0);
    next_cycle();
    applyStimulus(1'b1, 8'h50, 8'h05, 2'b01);
    @(negedge clk);
    checkOutput("flush_next_ready", 32'(in_ready), 32'd1);
    next_cycle();
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkOutput("flush_next_valid", 32'(out_valid), (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) checkOutput("flush_next_data", 32'(out_data), 32'h55);
      next_cycle();
    end

    // Reset mid-stream: two stalled items, the older one at the output
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'h81, 8'h18, 2'b01);
    next_cycle();
    applyStimulus(1'b1, 8'h66, 8'h0F, 2'b00);
    next_cycle();
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00);
    next_cycle();
    @(negedge clk);
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("pre_rst_data", 32'(out_data), 32'h99);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_data", 32'(out_data), 32'h00);
    next_cycle();
    next_cycle();
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      @(negedge clk);
      checkOutput("post_rst_no_item", 32'(out_valid), 32'd0);
    end
    next_cycle();

`ifdef COMBINE_PIPE_CNT_EN
    // Counter: 150 transfers, flush with two items in flight, 150 more
    checkOutput("cnt_reset", 32'(xfer_cnt), 32'd0);
    for (int c = 0; c < 152; c++) begin
      applyStimulus(1'b1, 8'(c), 8'hFF, 2'b00);
      next_cycle();
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    checkOutput("cnt_flush_valid", 32'(out_valid), 32'd0);
    checkOutput("cnt_mid", 32'(xfer_cnt), 32'd150);
    next_cycle();
    for (int c = 0; c < 150; c++) begin
      applyStimulus(1'b1, 8'(c), 8'h0F, 2'b01);
      next_cycle();
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00);
    for (int c = 0; c < 5; c++) next_cycle();
    @(negedge clk);
    checkOutput("cnt_drained", 32'(out_valid), 32'd0);
    checkOutput("cnt_final", 32'(xfer_cnt), 32'd44);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
